// File: rtl/equifill_strip_releaser.sv
// equifill_strip_releaser: per-strip fill/occupancy tracker for allocation notifications and releases
module equifill_strip_releaser #(
  parameter int NUM_STRIPS = 13,
  parameter int ARRAY_SIZE = 128
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      alloc_valid_i,
  output logic                      alloc_ready_o,
  input  logic [7:0]                alloc_x_i,
  input  logic [7:0]                alloc_y_i,
  input  logic [5:0]                alloc_w_i,
  input  logic                      rel_valid_i,
  output logic                      rel_ready_o,
  input  logic [7:0]                rel_x_i,
  input  logic [7:0]                rel_y_i,
  input  logic [5:0]                rel_w_i,
  output logic                      done_o,
  output logic [1:0]                err_o,
  output logic [8*NUM_STRIPS-1:0]   occupied_width_o
);
  localparam int SW = $clog2(NUM_STRIPS);

  typedef enum logic [1:0] {IDLE, LOOKUP, EXEC, RESP} state_t;

  // strip base rows; heights are implied by the gaps between consecutive bases
  function automatic logic [7:0] base_of(input logic [SW-1:0] s);
    case (s)
      4'd0:    return 8'd0;
      4'd1:    return 8'd16;
      4'd2:    return 8'd32;
      4'd3:    return 8'd48;
      4'd4:    return 8'd56;
      4'd5:    return 8'd64;
      4'd6:    return 8'd71;
      4'd7:    return 8'd80;
      4'd8:    return 8'd86;
      4'd9:    return 8'd96;
      4'd10:   return 8'd101;
      4'd11:   return 8'd112;
      4'd12:   return 8'd116;
      default: return 8'hff;
    endcase
  endfunction

  state_t          state, state_nx;
  logic            up, is_alloc, hit, take_a, take_r, last;
  logic [7:0]      x_q, y_q, f, l;
  logic [5:0]      w_q;
  logic [8:0]      sum;
  logic [SW-1:0]   cnt, idx;
  logic [1:0]      err_q, err_c;
  logic [7:0]      fill [NUM_STRIPS];
  logic [7:0]      live [NUM_STRIPS];

  // up holds ready low until the first edge after reset release
  always_comb begin
    alloc_ready_o = up && state == IDLE;
    rel_ready_o   = up && state == IDLE && !alloc_valid_i;
    take_a        = alloc_valid_i && alloc_ready_o;
    take_r        = rel_valid_i && rel_ready_o;
    last          = cnt == SW'(NUM_STRIPS - 1);
    done_o        = state == RESP;
    err_o         = done_o ? err_q : 2'd0;
    sum           = {1'b0, x_q} + {3'b0, w_q};
    f             = fill[idx];
    l             = live[idx];
    err_c         = !hit ? 2'd1 : w_q == 6'd0 ? 2'd2 :
                    is_alloc ? (x_q != f ? 2'd2 : sum > 9'(ARRAY_SIZE) ? 2'd3 : 2'd0) :
                               (sum > {1'b0, f} ? 2'd2 : l == 8'd0 ? 2'd3 : 2'd0);
    state_nx      = state == IDLE   ? ((take_a || take_r) ? LOOKUP : IDLE) :
                    state == LOOKUP ? (last ? EXEC : LOOKUP) :
                    state == EXEC   ? RESP : IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      up       <= 1'b0;
      is_alloc <= 1'b0;
      hit      <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      cnt      <= '0;
      idx      <= '0;
      err_q    <= '0;
      for (int i = 0; i < NUM_STRIPS; i++) begin
        fill[i] <= '0;
        live[i] <= '0;
      end
    end else begin
      up    <= 1'b1;
      state <= state_nx;
      if (take_a || take_r) begin
        is_alloc <= take_a;
        x_q      <= take_a ? alloc_x_i : rel_x_i;
        y_q      <= take_a ? alloc_y_i : rel_y_i;
        w_q      <= take_a ? alloc_w_i : rel_w_i;
        cnt      <= '0;
        hit      <= 1'b0;
        idx      <= '0;
      end
      if (state == LOOKUP) begin
        cnt <= cnt + 1'b1;
        if (y_q == base_of(cnt)) begin
          hit <= 1'b1;
          idx <= cnt;
        end
      end
      // emptying a strip resets its fill even if the freed span was not the tail
      if (state == EXEC) begin
        err_q <= err_c;
        if (err_c == 2'd0 && is_alloc) begin
          fill[idx] <= sum[7:0];
          live[idx] <= l + 8'd1;
        end else if (err_c == 2'd0) begin
          live[idx] <= l - 8'd1;
          fill[idx] <= l == 8'd1 ? 8'd0 : sum == {1'b0, f} ? x_q : f;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_STRIPS; g++) begin : g_occ
    assign occupied_width_o[8*g +: 8] = fill[g];
  end
endmodule

// File: tb/tb_equifill_strip_releaser.sv
// tb_equifill_strip_releaser: directed stimulus with a queue-based scoreboard checked on done_o
module tb_equifill_strip_releaser;
  logic         clk = 0;
  logic         rst_ni;
  logic         alloc_valid, rel_valid;
  logic         alloc_ready_o, rel_ready_o, done_o;
  logic [7:0]   alloc_x, alloc_y, rel_x, rel_y;
  logic [5:0]   alloc_w, rel_w;
  logic [1:0]   err_o;
  logic [103:0] occupied_width_o;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;

  typedef struct {
    int         h;
    logic [1:0] err;
    int         s;
    logic [7:0] fill;
  } exp_t;
  exp_t q[$];

  equifill_strip_releaser dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready_o),
    .alloc_x_i(alloc_x), .alloc_y_i(alloc_y), .alloc_w_i(alloc_w),
    .rel_valid_i(rel_valid), .rel_ready_o(rel_ready_o),
    .rel_x_i(rel_x), .rel_y_i(rel_y), .rel_w_i(rel_w),
    .done_o(done_o), .err_o(err_o), .occupied_width_o(occupied_width_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [103:0] act, input logic [103:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor: done_o must arrive 14 edges after the handshake edge with the queued result
  always @(negedge clk) begin
    if (!rst_ni) begin
      chk("reset_done", {103'd0, done_o}, 104'd0);
    end else if (done_o) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 104'd1, 104'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", 104'(cyc), 104'(e.h + 14));
        chk("err", {102'd0, err_o}, {102'd0, e.err});
        chk("fill", {96'd0, occupied_width_o[8*e.s +: 8]}, {96'd0, e.fill});
      end
    end else if (err_o != 2'd0) begin
      chk("err_idle", {102'd0, err_o}, 104'd0);
    end
  end

  task automatic op(input bit a, input logic [7:0] x, input logic [7:0] y, input logic [5:0] w,
                    input logic [1:0] e, input int s, input logic [7:0] f);
    int n = 0;
    @(negedge clk);
    if (a) begin
      alloc_valid = 1; alloc_x = x; alloc_y = y; alloc_w = w;
    end else begin
      rel_valid = 1; rel_x = x; rel_y = y; rel_w = w;
    end
    while (!(a ? alloc_ready_o : rel_ready_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("handshake_timeout", 104'd1, 104'd0);
    q.push_back('{cyc + 1, e, s, f});
    @(posedge clk);
    #1 alloc_valid = 0;
    rel_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 104'(q.size()), 104'd0);
  endtask

  initial begin
    int ha, n;
    rst_ni = 0; alloc_valid = 0; rel_valid = 0;
    alloc_x = 0; alloc_y = 0; alloc_w = 0; rel_x = 0; rel_y = 0; rel_w = 0;
    repeat (3) @(negedge clk);
    chk("reset_occ", occupied_width_o, 104'd0);
    chk("reset_rdy", {102'd0, alloc_ready_o, rel_ready_o}, 104'd0);
    rst_ni = 1;
    #1 chk("rdy_before_edge", {103'd0, alloc_ready_o}, 104'd0);
    @(posedge clk);
    #1 chk("rdy_after_edge", {102'd0, alloc_ready_o, rel_ready_o}, 104'd3);

    op(1, 0, 0, 20, 0, 0, 20);
    op(1, 0, 48, 10, 0, 3, 10);
    op(0, 0, 48, 10, 0, 3, 0);
    op(1, 0, 16, 30, 0, 1, 30);
    op(1, 30, 16, 40, 0, 1, 70);
    op(0, 0, 16, 30, 0, 1, 70);
    op(0, 30, 16, 40, 0, 1, 0);
    op(1, 0, 17, 5, 1, 0, 20);
    op(1, 5, 32, 4, 2, 2, 0);
    op(1, 0, 32, 50, 0, 2, 50);
    op(1, 50, 32, 50, 0, 2, 100);
    op(1, 100, 32, 40, 3, 2, 100);
    op(1, 100, 32, 28, 0, 2, 128);
    op(1, 128, 32, 1, 3, 2, 128);
    op(0, 0, 32, 50, 0, 2, 128);
    op(0, 50, 32, 50, 0, 2, 128);
    op(0, 100, 32, 28, 0, 2, 0);
    op(1, 0, 64, 0, 2, 5, 0);
    op(0, 0, 56, 5, 2, 4, 0);
    op(1, 0, 116, 12, 0, 12, 12);
    drain();
    chk("occ_snapshot", occupied_width_o, {8'd12, 88'd0, 8'd20});

    // simultaneous requests: alloc wins, release lands 16 edges later
    @(negedge clk);
    alloc_valid = 1; alloc_x = 20; alloc_y = 0; alloc_w = 5;
    rel_valid = 1; rel_x = 0; rel_y = 0; rel_w = 20;
    #1 chk("both_alloc_rdy", {103'd0, alloc_ready_o}, 104'd1);
    chk("both_rel_rdy", {103'd0, rel_ready_o}, 104'd0);
    ha = cyc + 1;
    q.push_back('{ha, 2'd0, 0, 8'd25});
    @(posedge clk);
    #1 alloc_valid = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rel_ready_o && n < 100);
    chk("rel_accept_cycle", 104'(cyc + 1), 104'(ha + 16));
    q.push_back('{cyc + 1, 2'd0, 0, 8'd25});
    @(posedge clk);
    #1 rel_valid = 0;
    drain();

    // abort in the fifth lookup cycle
    @(negedge clk);
    alloc_valid = 1; alloc_x = 25; alloc_y = 0; alloc_w = 9;
    #1 chk("abort_rdy", {103'd0, alloc_ready_o}, 104'd1);
    @(posedge clk);
    #1 alloc_valid = 0;
    repeat (4) @(posedge clk);
    #2 rst_ni = 0;
    #1 chk("abort_outs", {occupied_width_o}, 104'd0);
    chk("abort_flags", {100'd0, done_o, err_o, alloc_ready_o | rel_ready_o}, 104'd0);
    repeat (3) @(negedge clk);
    rst_ni = 1;
    @(posedge clk);
    #1 chk("abort_rdy_back", {102'd0, alloc_ready_o, rel_ready_o}, 104'd3);
    op(1, 0, 0, 7, 0, 0, 7);
    drain();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
